mission_sequencer: RTL and testbench

- Command-driven controller for one destructor machine.
- Accepts mission commands over a valid/ready handshake and drives the machine's green/yellow/red inputs to step it to a target level, retreat, or evade.
- Watches the machine's current_state, runs a watchdog, and returns one response code per command.
- Sits between the mission host and the destructor machine.

---
 rtl/mission_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mission_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mission_sequencer.sv
// rtl/mission_sequencer.sv - command-driven level sequencer for one destructor machine
// Steps the machine with green/yellow/red, runs a watchdog, and returns one response per command.
module mission_sequencer #(
  parameter int TIMEOUT    = 200,
  parameter int RED_CYCLES = 2,
  parameter int WD_W       = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_target,
  input  logic       abort,
  input  logic [3:0] unit_state,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [1:0] resp_code,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADV, S_RET, S_EVADE, S_RESP} state_t;

  localparam logic [1:0] OP_GOTO    = 2'b00;
  localparam logic [1:0] OP_EVADE   = 2'b01;
  localparam logic [1:0] OP_RETREAT = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic [1:0] RC_OK      = 2'b00;
  localparam logic [1:0] RC_FAIL    = 2'b01;
  localparam logic [1:0] RC_TIMEOUT = 2'b10;
  localparam logic [1:0] RC_REJECT  = 2'b11;

  localparam int RC_W = (RED_CYCLES < 2) ? 1 : $clog2(RED_CYCLES);
  localparam logic [RC_W-1:0] RED_LOAD = RC_W'(RED_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX   = '1;

  state_t            state;
  logic [1:0]        tgt_q;
  logic [WD_W-1:0]   wd;
  logic [RC_W-1:0]   red_cnt;

  logic              lvl_ok;
  logic [1:0]        lvl;
  logic              unit_fail;
  logic              unit_dec;
  logic [1:0]        goto_tgt;
  logic [WD_W-1:0]   wd_next;
  logic              wd_expired;

  // DECEPTION and FAIL carry no level; anything above EXPANSION is treated as FAIL.
  always_comb begin
    lvl_ok = 1'b1;
    lvl    = 2'd0;
    case (unit_state)
      4'd0:    lvl = 2'd0;
      4'd2:    lvl = 2'd1;
      4'd3:    lvl = 2'd2;
      4'd5:    lvl = 2'd3;
      default: lvl_ok = 1'b0;
    endcase
  end

  assign unit_fail  = (unit_state == 4'd4) || (unit_state > 4'd5);
  assign unit_dec   = (unit_state == 4'd1);
  assign goto_tgt   = (cmd_op == OP_RETREAT) ? 2'd0 : cmd_target;
  assign wd_next    = (wd == WD_MAX) ? wd : wd + WD_W'(1);
  assign wd_expired = (wd_next >= WD_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tgt_q      <= 2'd0;
      wd         <= '0;
      red_cnt    <= '0;
      cmd_ready  <= 1'b0;
      green      <= 1'b0;
      yellow     <= 1'b0;
      red        <= 1'b0;
      resp_valid <= 1'b0;
      resp_code  <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wd        <= '0;
            tgt_q     <= goto_tgt;
            if (cmd_op == OP_RSVD || !lvl_ok ||
                (cmd_op != OP_EVADE && lvl == 2'd3 && goto_tgt < 2'd3)) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_code  <= RC_REJECT;
            end else if (cmd_op == OP_EVADE) begin
              state   <= S_EVADE;
              red     <= 1'b1;
              red_cnt <= RED_LOAD;
            end else if (goto_tgt > lvl) begin
              state <= S_ADV;
              green <= 1'b1;
            end else if (goto_tgt < lvl) begin
              state  <= S_RET;
              yellow <= 1'b1;
            end else begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_code  <= RC_OK;
            end
          end
        end

        S_ADV, S_RET: begin
          wd <= wd_next;
          // abort beats completion; the watchdog keeps running into EVADE
          if (abort) begin
            state   <= S_EVADE;
            green   <= 1'b0;
            yellow  <= 1'b0;
            red     <= 1'b1;
            red_cnt <= RED_LOAD;
          end else if (unit_dec || unit_fail || (lvl_ok && lvl == tgt_q) || wd_expired) begin
            state      <= S_RESP;
            green      <= 1'b0;
            yellow     <= 1'b0;
            resp_valid <= 1'b1;
            if (unit_dec || unit_fail)
              resp_code <= RC_FAIL;
            else if (lvl_ok && lvl == tgt_q)
              resp_code <= RC_OK;
            else
              resp_code <= RC_TIMEOUT;
          end
        end

        S_EVADE: begin
          wd <= wd_next;
          if (red_cnt != '0)
            red_cnt <= red_cnt - RC_W'(1);
          else
            red <= 1'b0;
          if (unit_fail || (!red && unit_state == 4'd0) || wd_expired) begin
            state      <= S_RESP;
            red        <= 1'b0;
            resp_valid <= 1'b1;
            if (unit_fail)
              resp_code <= RC_FAIL;
            else if (!red && unit_state == 4'd0)
              resp_code <= RC_OK;
            else
              resp_code <= RC_TIMEOUT;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          green      <= 1'b0;
          yellow     <= 1'b0;
          red        <= 1'b0;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mission_sequencer.sv
// tb/tb_mission_sequencer.sv - directed self-checking bench for mission_sequencer
module tb_mission_sequencer;

  logic       clock;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_target;
  logic       abort;
  logic [3:0] unit_state;
  logic       green;
  logic       yellow;
  logic       red;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_code;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  mission_sequencer #(.TIMEOUT(200), .RED_CYCLES(2), .WD_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_target (cmd_target),
    .abort      (abort),
    .unit_state (unit_state),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_code  (resp_code),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] tgt);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_target = tgt;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic take_resp(input string tag, input logic [1:0] exp_code);
    for (int i = 0; i < 300 && !resp_valid; i++) tick();
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_code"}, resp_code, exp_code);
    check({tag, "_drv"}, {green, yellow, red}, 3'b000);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_done"}, resp_valid, 0);
    check({tag, "_rdy"}, cmd_ready, 1);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_target = 2'd0;
    abort      = 1'b0;
    unit_state = 4'd0;
    resp_ready = 1'b0;
    tick();
    tick();
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_outs", {green, yellow, red, resp_valid, resp_code}, 6'b0);
    reset_n = 1'b1;
    tick();
    check("rel_ready", cmd_ready, 1);

    // GOTO 2 from LAY_LOW: advance through 2 and 3
    send_cmd(2'b00, 2'd2);
    check("adv_green", green, 1);
    check("adv_busy", busy, 1);
    check("adv_ready", cmd_ready, 0);
    for (int i = 0; i < 19; i++) tick();
    unit_state = 4'd2;
    tick();
    check("adv_mid", {green, resp_valid}, 2'b10);
    for (int i = 0; i < 19; i++) tick();
    unit_state = 4'd3;
    tick();
    check("adv_done_green", green, 0);
    take_resp("adv", 2'b00);
    check("adv_idle_busy", busy, 0);

    // GOTO 0 from DATABASE: yellow only, OK only at LAY_LOW
    send_cmd(2'b00, 2'd0);
    check("ret_drv", {green, yellow, red}, 3'b010);
    unit_state = 4'd2;
    tick();
    check("ret_mid", {green, yellow, red, resp_valid}, 4'b0100);
    unit_state = 4'd0;
    tick();
    take_resp("ret", 2'b00);

    // abort in the same cycle as completion: EVADE wins, red for two cycles
    send_cmd(2'b00, 2'd1);
    check("ab_green", green, 1);
    tick();
    unit_state = 4'd2;
    abort      = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_evade", {green, red, resp_valid}, 3'b010);
    tick();
    check("ab_red2", red, 1);
    tick();
    check("ab_red3", red, 0);
    tick();
    check("ab_wait", resp_valid, 0);
    unit_state = 4'd0;
    tick();
    take_resp("ab", 2'b00);

    // EVADE ending in FAIL, then a GOTO against a failed unit
    send_cmd(2'b01, 2'd0);
    check("ev_red", red, 1);
    unit_state = 4'd4;
    tick();
    take_resp("evf", 2'b01);
    send_cmd(2'b00, 2'd1);
    take_resp("rej_fail", 2'b11);

    // equal target completes without any drive; EXPANSION refuses a lower GOTO
    unit_state = 4'd2;
    send_cmd(2'b00, 2'd1);
    take_resp("eq", 2'b00);
    unit_state = 4'd5;
    send_cmd(2'b00, 2'd1);
    take_resp("rej_exp", 2'b11);

    // RETREAT_LOW from SECURITY
    unit_state = 4'd2;
    send_cmd(2'b10, 2'd3);
    check("rl_yellow", yellow, 1);
    unit_state = 4'd0;
    tick();
    take_resp("rl", 2'b00);

    // timeout with the unit frozen
    send_cmd(2'b00, 2'd3);
    for (int i = 0; i < 199; i++) tick();
    check("to_before", {green, resp_valid}, 2'b10);
    tick();
    check("to_at", {green, resp_valid, resp_code}, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("to_hold", {resp_valid, resp_code}, 3'b110);
    end
    take_resp("to", 2'b10);

    // reserved op, then reset in the middle of an advance
    send_cmd(2'b11, 2'd0);
    take_resp("rsvd", 2'b11);
    send_cmd(2'b00, 2'd2);
    tick();
    check("mr_green", green, 1);
    reset_n = 1'b0;
    #1;
    check("mr_async", {green, busy, resp_valid, cmd_ready}, 4'b0000);
    tick();
    tick();
    check("mr_noresp", resp_valid, 0);
    reset_n = 1'b1;
    tick();
    check("mr_ready", cmd_ready, 1);
    check("mr_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
